// File: rtl/irq_encoder_32x5_pkg.sv
// Shared constants, output-stage state encoding and the one-hot helper for the
// 32-line request encoder (and its companion 5x32 decoder).
package irq_encoder_32x5_pkg;

    localparam int unsigned N = 32;
    localparam int unsigned W = 5;

    // Output stage: IDLE has nothing presented, HOLD has an unacknowledged index.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } out_state_t;

    // Index to one-hot mask; shared with the decoder.
    function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
        logic [N-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/irq_encoder_32x5_priority_enc.sv
// Purely combinational lowest-index-first priority encoder: pending -> sel, any.
module priority_enc_32x5
    import irq_encoder_32x5_pkg::*;
#(
    parameter int unsigned NR = N,
    parameter int unsigned WI = W
) (
    input  logic [NR-1:0] pending,
    output logic [WI-1:0] sel,
    output logic          any
);

    // Scan upward and keep only the first set bit found.
    always_comb begin
        sel = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (pending[i] && !any) begin
                sel = WI'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_encoder_32x5.sv
// Registered 32-to-5 request encoder: collects request strobes into a pending
// register, issues the lowest pending index over a valid/ack handshake and
// flags requests that land on an already-pending bit.
module irq_encoder_32x5
    import irq_encoder_32x5_pkg::*;
#(
    parameter int unsigned NR = N,
    parameter int unsigned WI = W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [NR-1:0] REQ,
    input  logic          CLR_ALL,
    output logic [WI-1:0] IDX,
    output logic          VALID,
    input  logic          ACK,
    output logic [NR-1:0] PENDING,
    output logic          OVERRUN
);

    out_state_t    state;
    out_state_t    state_next;
    logic [NR-1:0] pending;
    logic [NR-1:0] pending_next;
    logic [NR-1:0] issue_mask;
    logic [WI-1:0] idx;
    logic [WI-1:0] idx_next;
    logic [WI-1:0] sel;
    logic          any;
    logic          load;
    logic          overrun;
    logic          overrun_next;

    priority_enc_32x5 #(
        .NR (NR),
        .WI (WI)
    ) u_enc (
        .pending (pending),
        .sel     (sel),
        .any     (any)
    );

    // Issue decision and pending/overrun update; REQ re-arms a bit issued this cycle.
    always_comb begin
        load         = 1'b0;
        issue_mask   = '0;
        pending_next = pending;
        overrun_next = overrun;
        if (CLR_ALL) begin
            pending_next = '0;
            overrun_next = 1'b0;
        end else begin
            load         = any && ((state == ST_IDLE) || ACK);
            issue_mask   = load ? onehot(sel) : '0;
            pending_next = (pending & ~issue_mask) | REQ;
            overrun_next = overrun | (|(REQ & pending & ~issue_mask));
        end
    end

    // Output stage next state; IDX only changes on a load and holds otherwise.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        if (CLR_ALL) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state_next = ST_HOLD;
                        idx_next   = sel;
                    end
                end
                ST_HOLD: begin
                    if (ACK) begin
                        if (load) begin
                            idx_next = sel;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            idx     <= '0;
            pending <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            pending <= pending_next;
            overrun <= overrun_next;
        end
    end

    assign IDX     = idx;
    assign VALID   = (state == ST_HOLD);
    assign PENDING = pending;
    assign OVERRUN = overrun;

endmodule
